serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, giving operand/result width; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high; one clock, synchronous active-high reset, sampled on clk rising edge only.
REQ-004 The block SHALL have port start, input, 1 bit: request a new operation; sampled only when accepted (REQ-011).
REQ-005 The block SHALL have port mode, input, 1 bit: 0 = add, 1 = subtract; sampled with start.
REQ-006 The block SHALL have ports x and y, input, WIDTH bits: operands, unsigned or two's complement; sampled with start.
REQ-007 The block SHALL have port cin, input, 1 bit: carry-in (add) or borrow-in (subtract); sampled with start.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse; res/cout/ovf newly valid.
REQ-010 The block SHALL have ports res (output, WIDTH bits: result), cout (output, 1 bit: carry-out; in subtract 1 = no borrow) and ovf (output, 1 bit: signed overflow).

Function
REQ-011 The FSM SHALL have states IDLE, RUN and DONE; start is accepted in IDLE and DONE, and ignored in RUN.
REQ-012 On acceptance: latch a = x; b = y (mode=0) or ~y (mode=1); carry = cin (mode=0) or ~cin (mode=1); bit counter = 0; go to RUN.
REQ-013 Each RUN cycle SHALL process one bit, LSB first, with a single full-adder cell: s = a[0]^b[0]^carry, carry <= majority(a[0],b[0],carry); a and b shift right; s shifts into an internal result register at the MSB.
REQ-014 RUN SHALL last exactly WIDTH cycles; on the edge that processes bit WIDTH-1 the FSM SHALL go to DONE and load res, cout = final carry, and ovf = (carry into bit WIDTH-1) XOR (final carry).
REQ-015 Latency: start accepted at edge E0 SHALL give busy=1 after E0 through edge E0+WIDTH, and done=1 for exactly the one cycle after edge E0+WIDTH.
REQ-016 From DONE the FSM SHALL go to IDLE, or to RUN if start=1 (back-to-back; done and the new busy are both high in that cycle).
REQ-017 res, cout and ovf SHALL change only on the edge that enters DONE, or on reset, and SHALL hold otherwise, including throughout a later RUN.
REQ-018 Result arithmetic SHALL be modulo 2^WIDTH; add = x+y+cin; subtract = x-y-cin.
REQ-019 A start held high continuously SHALL start a new operation each time the FSM is in IDLE or DONE; it SHALL NOT queue requests made during RUN.

Reset
REQ-020 With rst=1 at an edge, the FSM SHALL go to IDLE and busy, done, res, cout, ovf, the carry and the counter SHALL all become 0.
REQ-021 rst SHALL take priority over start, including mid-RUN; an aborted operation SHALL never pulse done.

Verification (WIDTH=8 unless noted)
REQ-022 Reset: hold rst 2 cycles with start=1 -> busy=0, done=0, res=8'h00, cout=0, ovf=0; no operation starts.
REQ-023 Add, latency check: x=8'h3C, y=8'h05, cin=0, mode=0 -> busy high exactly 8 cycles, done one cycle later per REQ-015, res=8'h41, cout=0, ovf=0.
REQ-024 Add edge cases:
- 8'hFF+8'h01, cin=1 -> res=8'h01, cout=1, ovf=0.
- 8'h7F+8'h01, cin=0 -> res=8'h80, cout=0, ovf=1.
REQ-025 Subtract:
- 8'h10-8'h20, cin=0 -> res=8'hF0, cout=0, ovf=0.
- 8'h80-8'h01, cin=0 -> res=8'h7F, cout=1, ovf=1.
- 8'h05-8'h05, cin=1 -> res=8'hFF, cout=0.
REQ-026 Control:
- start pulsed mid-RUN with different operands -> ignored; the first result is unchanged.
- start held in DONE -> back-to-back operation, res held until its own done.
- rst asserted at RUN cycle 4 -> IDLE next edge, no done pulse, outputs 0.
REQ-027 Exhaustive, WIDTH=4: all x, y, cin, mode (1024 cases) -> res, cout and ovf match the reference arithmetic of REQ-014/REQ-018, and done arrives exactly WIDTH edges after acceptance.

Source files
------------

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial add/subtract, one full-adder cell, LSB first,
//               WIDTH cycles per operation with carry-out and overflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             cout,
    output logic             ovf
);

    localparam int c_CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [c_CW-1:0]  r_cnt;
    logic [WIDTH-2:0] r_sum;
    logic [WIDTH-1:0] r_res;
    logic             r_cout;
    logic             r_ovf;

    logic             w_accept;
    logic             w_last;
    logic             w_s;
    logic             w_c;
    logic [WIDTH-1:0] w_shift;

    assign w_accept = start && (r_state != RUN);
    assign w_last   = (r_cnt == c_CW'(WIDTH - 1));
    assign w_s      = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_c      = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
    // New sum bit enters at the MSB; on the final bit this is the full result.
    assign w_shift  = {w_s, r_sum};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) w_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                // A back-to-back request shows the new operation as busy already.
                busy = start;
                w_next = start ? RUN : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_res   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= x;
            r_b     <= mode ? ~y : y;
            r_carry <= cin ^ mode;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_carry <= w_c;
            r_cnt   <= r_cnt + c_CW'(1);
            r_sum   <= w_shift[WIDTH-1:1];
            if (w_last) begin
                r_res  <= w_shift;
                r_cout <= w_c;
                r_ovf  <= r_carry ^ w_c;
            end
        end
    end

    assign res  = r_res;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Scoreboard bench for serial_adder (WIDTH=8 and WIDTH=4 copies).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       st8 = 1'b0, md8 = 1'b0, ci8 = 1'b0;
    logic [7:0] x8 = '0, y8 = '0;
    logic       busy8, done8, co8, ov8;
    logic [7:0] res8;
    logic       st4 = 1'b0, md4 = 1'b0, ci4 = 1'b0;
    logic [3:0] x4 = '0, y4 = '0;
    logic       busy4, done4, co4, ov4;
    logic [3:0] res4;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(st8), .mode(md8), .x(x8), .y(y8), .cin(ci8),
        .busy(busy8), .done(done8), .res(res8), .cout(co8), .ovf(ov8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(st4), .mode(md4), .x(x4), .y(y4), .cin(ci4),
        .busy(busy4), .done(done4), .res(res4), .cout(co4), .ovf(ov4)
    );

    typedef struct {
        longint res;
        bit     cout;
        bit     ovf;
        int     acc;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];
    exp_t e8, e4;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic exp_t ref_op(int w, longint x, longint y, bit cin, bit mode);
        exp_t   e;
        longint m  = longint'(1) << w;
        longint sx = (x >= m / 2) ? x - m : x;
        longint sy = (y >= m / 2) ? y - m : y;
        longint u, s;
        if (!mode) begin
            u      = x + y + longint'(cin);
            s      = sx + sy + longint'(cin);
            e.cout = (u >= m);
        end else begin
            u      = x - y - longint'(cin);
            s      = sx - sy - longint'(cin);
            e.cout = (u >= 0);
        end
        e.res = ((u % m) + m) % m;
        e.ovf = (s > m / 2 - 1) || (s < -(m / 2));
        e.acc = 0;
        return e;
    endfunction

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one request; returns just after the accepting edge.
    task automatic issue(int w, longint x, longint y, bit cin, bit mode, bit keep);
        exp_t e;
        @(negedge clk);
        if (w == 8) begin
            x8 = x[7:0]; y8 = y[7:0]; ci8 = cin; md8 = mode; st8 = 1'b1;
        end else begin
            x4 = x[3:0]; y4 = y[3:0]; ci4 = cin; md4 = mode; st4 = 1'b1;
        end
        @(posedge clk);
        #1;
        e     = ref_op(w, x, y, cin, mode);
        e.acc = cyc;
        if (w == 8) begin
            q8.push_back(e);
            if (!keep) st8 = 1'b0;
        end else begin
            q4.push_back(e);
            if (!keep) st4 = 1'b0;
        end
    endtask

    task automatic wait_done(int w);
        int n = 0;
        @(negedge clk);
        while (!((w == 8) ? done8 : done4) && n < w + 4) begin
            @(negedge clk);
            n++;
        end
        if (!((w == 8) ? done8 : done4)) chk("done_timeout", 0, 1);
    endtask

    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) begin
                chk("done8_unexpected", 1, 0);
            end else begin
                e8 = q8.pop_front();
                chk("res8", res8, e8.res);
                chk("cout8", co8, e8.cout);
                chk("ovf8", ov8, e8.ovf);
                chk("latency8", cyc - e8.acc, 8);
            end
        end
    end

    always @(negedge clk) begin
        if (done4) begin
            if (q4.size() == 0) begin
                chk("done4_unexpected", 1, 0);
            end else begin
                e4 = q4.pop_front();
                chk("res4", res4, e4.res);
                chk("cout4", co4, e4.cout);
                chk("ovf4", ov4, e4.ovf);
                chk("latency4", cyc - e4.acc, 4);
            end
        end
    end

    initial begin
        exp_t a;
        longint dx [5] = '{64'hFF, 64'h7F, 64'h10, 64'h80, 64'h05};
        longint dy [5] = '{64'h01, 64'h01, 64'h20, 64'h01, 64'h05};
        bit     dc [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        bit     dm [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        // Reset held two cycles with start asserted
        st8 = 1'b1; x8 = 8'hA5; y8 = 8'h5A;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_res", res8, 0);
        chk("rst_cout", co8, 0);
        chk("rst_ovf", ov8, 0);
        rst = 1'b0; st8 = 1'b0;
        @(negedge clk);
        chk("rst_no_start", busy8, 0);

        // Latency: busy for exactly 8 cycles, then one done cycle
        issue(8, 64'h3C, 64'h05, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("lat_run_busy_done", {busy8, done8}, 2'b10);
        end
        @(negedge clk);
        chk("lat_done_busy_done", {busy8, done8}, 2'b01);
        chk("lat_res", res8, 8'h41);
        @(negedge clk);
        chk("lat_done_once", done8, 0);

        for (int i = 0; i < 5; i++) begin
            issue(8, dx[i], dy[i], dc[i], dm[i], 1'b0);
            wait_done(8);
        end

        // Start pulsed mid-RUN is ignored
        issue(8, 64'h11, 64'h22, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        x8 = 8'hAA; y8 = 8'h55; st8 = 1'b1;
        @(negedge clk);
        st8 = 1'b0;
        wait_done(8);
        repeat (10) @(negedge clk);
        chk("midrun_res_kept", res8, 8'h33);

        // Back-to-back: start held into DONE
        a = ref_op(8, 64'hC8, 64'h64, 1'b1, 1'b0);
        issue(8, 64'hC8, 64'h64, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        x8 = 8'h03; y8 = 8'h09; ci8 = 1'b0; md8 = 1'b1;
        wait_done(8);
        chk("b2b_busy_in_done", busy8, 1);
        chk("b2b_res_a", res8, a.res);
        @(posedge clk);
        #1;
        begin
            exp_t b;
            b     = ref_op(8, 64'h03, 64'h09, 1'b0, 1'b1);
            b.acc = cyc;
            q8.push_back(b);
        end
        st8 = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("b2b_res_held", res8, a.res);
        end
        wait_done(8);

        // Reset during RUN cycle 4 aborts with no done
        issue(8, 64'h9C, 64'h3B, 1'b1, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        q8.delete();
        @(negedge clk);
        chk("abort_busy", busy8, 0);
        chk("abort_done", done8, 0);
        chk("abort_res", res8, 0);
        chk("abort_cout", co8, 0);
        chk("abort_ovf", ov8, 0);
        rst = 1'b0;
        repeat (12) @(negedge clk);

        // Random WIDTH=8 traffic
        repeat (40) begin
            issue(8, longint'($urandom_range(0, 255)), longint'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            wait_done(8);
        end

        // Exhaustive WIDTH=4
        for (int m = 0; m < 2; m++)
            for (int c = 0; c < 2; c++)
                for (int xi = 0; xi < 16; xi++)
                    for (int yi = 0; yi < 16; yi++) begin
                        issue(4, longint'(xi), longint'(yi), 1'(c), 1'(m), 1'b0);
                        wait_done(4);
                    end

        repeat (3) @(negedge clk);
        chk("q8_drained", q8.size(), 0);
        chk("q4_drained", q4.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
